// File: rtl/branch_ctrl.sv
// branch_ctrl: branch resolution controller sitting between the ID stage and
// the Branch compare unit. It enables the compare when operands are ready,
// stalls ID while waiting for operands or for fetch to take a redirect, and
// issues a PC redirect one cycle after a taken evaluation (delay slot).
// Optional statistics counters are built only when BRANCH_STATS_EN is defined;
// otherwise takenCount/notTakenCount are tied to zero.
module branch_ctrl #(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              idValid,
    input  logic              idBraEnable,
    input  logic [2:0]        idBraOp,
    input  logic [31:0]       idTarget,
    input  logic              opndReady,
    input  logic              takeBranch,
    output logic              braEnable,
    output logic [2:0]        braOp,
    output logic              stallId,
    output logic              redirectValid,
    output logic [31:0]       redirectPc,
    input  logic              redirectReady,
    input  logic              flush,
    output logic              errIllegalOp,
    output logic [STAT_W-1:0] takenCount,
    output logic [STAT_W-1:0] notTakenCount
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_OPND = 2'd1,
        REDIRECT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] target_q, target_d;
    logic        eval;       // branch is evaluated this cycle
    logic        taken;      // evaluated branch resolves taken
    logic        illegal_op;

    assign illegal_op = (idBraOp == 3'd6) || (idBraOp == 3'd7);

    // Next-state and combinational outputs; flush and reset override everything.
    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        eval         = 1'b0;
        taken        = 1'b0;
        braEnable    = 1'b0;
        braOp        = 3'd0;
        stallId      = 1'b0;
        errIllegalOp = 1'b0;

        if (flush || !rst_n) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (idValid && idBraEnable) begin
                        if (opndReady) begin
                            eval = 1'b1;
                        end else begin
                            stallId = 1'b1;
                            state_d = WAIT_OPND;
                        end
                    end
                end
                // ID is held by the stall, so the branch fields remain valid here.
                WAIT_OPND: begin
                    if (opndReady) begin
                        eval = 1'b1;
                    end else begin
                        stallId = 1'b1;
                    end
                end
                REDIRECT: begin
                    if (redirectReady) begin
                        state_d = IDLE;
                    end else begin
                        stallId = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (eval) begin
                braEnable    = 1'b1;
                braOp        = idBraOp;
                errIllegalOp = illegal_op;
                taken        = takeBranch && !illegal_op;
                if (taken) begin
                    state_d  = REDIRECT;
                    target_d = idTarget;
                end else begin
                    state_d  = IDLE;
                end
            end
        end
    end

    // State and captured target register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            target_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    assign redirectValid = (state_q == REDIRECT);
    assign redirectPc    = redirectValid ? target_q : 32'd0;

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] taken_cnt_q, not_taken_cnt_q;

    // Saturating count of taken evaluations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_q <= '0;
        end else if (eval && taken && (taken_cnt_q != {STAT_W{1'b1}})) begin
            taken_cnt_q <= taken_cnt_q + 1'b1;
        end
    end

    // Saturating count of not-taken evaluations (illegal ops count here).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            not_taken_cnt_q <= '0;
        end else if (eval && !taken && (not_taken_cnt_q != {STAT_W{1'b1}})) begin
            not_taken_cnt_q <= not_taken_cnt_q + 1'b1;
        end
    end

    assign takenCount    = taken_cnt_q;
    assign notTakenCount = not_taken_cnt_q;
`else
    assign takenCount    = '0;
    assign notTakenCount = '0;
`endif

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 The block SHALL have parameter STAT_W, default 16: width of the statistics counters.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port idValid, input, 1: the ID stage holds a valid instruction.
REQ-005 The block SHALL have port idBraEnable, input, 1: the ID instruction is a conditional branch.
REQ-006 The block SHALL have port idBraOp, input, 3: 0 BEQ, 1 BNE, 2 BGEZ, 3 BGTZ, 4 BLEZ, 5 BLTZ; 6 and 7 are illegal.
REQ-007 The block SHALL have port idTarget, input, 32: the branch target address.
REQ-008 The block SHALL have port opndReady, input, 1: the forwarded rs/rt values are valid this cycle.
REQ-009 The block SHALL have port takeBranch, input, 1: the combinational compare result from the Branch unit.
REQ-010 The block SHALL have port braEnable, output, 1: the Branch unit enable.
REQ-011 The block SHALL have port braOp, output, 3: the Branch unit opcode.
REQ-012 The block SHALL have port stallId, output, 1: hold the IF and ID stages.
REQ-013 The block SHALL have port redirectValid, output, 1: a PC redirect request.
REQ-014 The block SHALL have port redirectPc, output, 32: the redirect address.
REQ-015 The block SHALL have port redirectReady, input, 1: fetch accepts the redirect.
REQ-016 The block SHALL have port flush, input, 1: exception flush; it has the highest priority.
REQ-017 The block SHALL have port errIllegalOp, output, 1: a one-cycle pulse on an illegal braOp.
REQ-018 The block SHALL have ports takenCount and notTakenCount, output, STAT_W each: branch statistics.

Function
REQ-019 The block SHALL implement the FSM states IDLE, WAIT_OPND and REDIRECT.
REQ-020 In IDLE, when idValid and idBraEnable and opndReady, the block SHALL evaluate in the same cycle: braEnable=1, braOp=idBraOp, and the values of takeBranch and idTarget registered.
REQ-021 On evaluation with takeBranch=1, the block SHALL go to REDIRECT; with takeBranch=0, it SHALL stay in IDLE with no redirect.
REQ-022 In IDLE, when idValid and idBraEnable and !opndReady, the block SHALL go to WAIT_OPND with stallId=1 in that same cycle.
REQ-023 In WAIT_OPND, the block SHALL hold stallId=1 and braEnable=0 until opndReady, then evaluate per REQ-020 and REQ-021 with stallId=0 in that cycle; the wait is unbounded.
REQ-024 Outside an evaluation cycle, the block SHALL drive braEnable=0 and braOp=0.
REQ-025 In REDIRECT, the block SHALL assert redirectValid=1 with redirectPc equal to the registered target; redirectPc SHALL be 0 when redirectValid=0.
REQ-026 Redirect timing SHALL be as follows: redirectValid first rises the cycle after evaluation, so the delay-slot instruction is fetched during evaluation and executes normally.
REQ-027 In REDIRECT, redirectValid and redirectPc SHALL hold stable until redirectReady=1; on that cycle the block returns to IDLE.
REQ-028 In REDIRECT, stallId SHALL be 1 while redirectReady=0, and no new branch is evaluated in that state.
REQ-029 An illegal braOp (6 or 7) SHALL be evaluated as not-taken, ignoring takeBranch, and SHALL pulse errIllegalOp for one cycle.
REQ-030 An instruction with idBraEnable=1 and idValid=0 SHALL be ignored.
REQ-031 flush=1 in any state SHALL force IDLE on the next edge, drop any pending redirect, suppress evaluation and statistics updates in that cycle, and deassert stallId combinationally.
REQ-032 Simultaneous flush and redirectReady SHALL be treated as a flush; the redirect is not counted as delivered.

Reset
REQ-033 rst_n=0 SHALL asynchronously force state IDLE, stallId=0, redirectValid=0, redirectPc=0, braEnable=0, braOp=0, errIllegalOp=0, and both counters to 0.
REQ-034 Reset mid-REDIRECT SHALL discard the redirect; after release, the block starts in IDLE on the first edge.

Configuration
REQ-035 With macro BRANCH_STATS_EN defined, takenCount SHALL increment on each taken evaluation and notTakenCount on each not-taken evaluation, illegal ops included.
REQ-036 With BRANCH_STATS_EN defined, both counters SHALL saturate at 2^STAT_W-1 and never wrap.
REQ-037 Without BRANCH_STATS_EN, takenCount and notTakenCount SHALL be constant 0 and no counter registers SHALL be built.

Verification
REQ-038 Scenario: BEQ, opndReady=1, takeBranch=1, idTarget=0x00400020, redirectReady=1 -> braEnable=1 in cycle N; redirectValid=1 and redirectPc=0x00400020 in cycle N+1 only; stallId=0 throughout.
REQ-039 Scenario: BGTZ with opndReady low for 3 cycles, then takeBranch=0 -> stallId=1 for exactly 3 cycles; no redirect; notTakenCount=1 with the macro.
REQ-040 Scenario: BNE taken, redirectReady low for 2 cycles -> redirectValid held 3 cycles with a stable PC; stallId=1 during the 2 wait cycles.
REQ-041 Scenario: braOp=7 with takeBranch=1 -> no redirect; errIllegalOp pulses one cycle.
REQ-042 Scenario: flush asserted in REDIRECT together with redirectReady=1 -> redirectValid=0 next cycle; state IDLE; counters unchanged by the flush.
REQ-043 Scenario: rst_n pulsed low mid-WAIT_OPND, off a clock edge -> all outputs 0 immediately; a new BLTZ after release evaluates normally.
